// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants, control-word struct and forwarding helper
//               for the MIPS pipeline control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT = 4'b0111;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    // The younger producer (EX/MEM) always wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             exmem_we,
        input logic [REG_W-1:0] exmem_dest,
        input logic             memwb_we,
        input logic [REG_W-1:0] memwb_dest
    );
        if (exmem_we && (exmem_dest != '0) && (exmem_dest == src))
            return FWD_EXMEM;
        else if (memwb_we && (memwb_dest != '0) && (memwb_dest == src))
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
// Module      : main_decoder
// Description : Combinational opcode/funct decode into the control word.
// Revision    : 1.0 - initial release
// ============================================================================
module main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_nop,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                case (i_funct)
                    FN_ADD:  o_ctrl.alu_op = ALU_OP_ADD;
                    FN_SUB:  o_ctrl.alu_op = ALU_OP_SUB;
                    FN_AND:  o_ctrl.alu_op = ALU_OP_AND;
                    FN_OR:   o_ctrl.alu_op = ALU_OP_OR;
                    FN_SLT:  o_ctrl.alu_op = ALU_OP_SLT;
                    default: begin
                        // The all-zero word is the pipeline NOP, not an error.
                        o_ctrl    = '0;
                        o_illegal = !i_nop;
                    end
                endcase
            end
            OP_ADDI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_op     = ALU_OP_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            OP_BEQ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_OP_SUB;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_control_unit
// Description : Control pipeline (ID/EX, EX/MEM, MEM/WB), load-use stall,
//               branch flush and EX-stage forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [INSTR_W-1:0]    id_instr,
    input  logic                  ex_zero,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  pc_src,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  illegal_instr
);

    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_nop;
    ctrl_t                 w_dec_ctrl;
    logic                  w_dec_illegal;
    logic [REG_ADDR_W-1:0] w_dest;
    logic                  w_stall;
    logic                  w_take;

    ctrl_t                 r_idex_ctrl;
    logic [REG_ADDR_W-1:0] r_idex_rs;
    logic [REG_ADDR_W-1:0] r_idex_rt;
    logic [REG_ADDR_W-1:0] r_idex_dest;
    logic                  r_exmem_mem_read;
    logic                  r_exmem_mem_write;
    logic                  r_exmem_reg_write;
    logic                  r_exmem_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_exmem_dest;
    logic                  r_memwb_reg_write;
    logic                  r_memwb_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_memwb_dest;
    logic                  r_illegal;

    assign w_opcode = id_instr[31:26];
    assign w_funct  = id_instr[5:0];
    assign w_rs     = id_instr[21 +: REG_ADDR_W];
    assign w_rt     = id_instr[16 +: REG_ADDR_W];
    assign w_rd     = id_instr[11 +: REG_ADDR_W];
    assign w_nop    = (id_instr == '0);

    main_decoder u_main_decoder (
        .i_opcode  (w_opcode),
        .i_funct   (w_funct),
        .i_nop     (w_nop),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        w_dest = '0;
        if (w_dec_ctrl.reg_write)
            w_dest = w_dec_ctrl.reg_dst ? w_rd : w_rt;
    end

    // Stall is conservative: any ID reader of the load target waits, even sw/beq.
    assign w_stall = r_idex_ctrl.mem_read && (r_idex_rt != '0) &&
                     ((r_idex_rt == w_rs) || (r_idex_rt == w_rt));
    assign w_take  = r_idex_ctrl.branch && ex_zero;

    always_comb begin
        pc_write   = en && (w_take || !w_stall);
        ifid_write = en && (w_take || !w_stall);
        ifid_flush = en && w_take;
        pc_src     = en && w_take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex_ctrl        <= '0;
            r_idex_rs          <= '0;
            r_idex_rt          <= '0;
            r_idex_dest        <= '0;
            r_exmem_mem_read   <= 1'b0;
            r_exmem_mem_write  <= 1'b0;
            r_exmem_reg_write  <= 1'b0;
            r_exmem_mem_to_reg <= 1'b0;
            r_exmem_dest       <= '0;
            r_memwb_reg_write  <= 1'b0;
            r_memwb_mem_to_reg <= 1'b0;
            r_memwb_dest       <= '0;
            r_illegal          <= 1'b0;
        end else if (en) begin
            if (w_stall || w_take || w_dec_illegal) begin
                r_idex_ctrl <= '0;
                r_idex_rs   <= '0;
                r_idex_rt   <= '0;
                r_idex_dest <= '0;
            end else begin
                r_idex_ctrl <= w_dec_ctrl;
                r_idex_rs   <= w_rs;
                r_idex_rt   <= w_rt;
                r_idex_dest <= w_dest;
            end
            r_exmem_mem_read   <= r_idex_ctrl.mem_read;
            r_exmem_mem_write  <= r_idex_ctrl.mem_write;
            r_exmem_reg_write  <= r_idex_ctrl.reg_write;
            r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
            r_exmem_dest       <= r_idex_dest;
            r_memwb_reg_write  <= r_exmem_reg_write;
            r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
            r_memwb_dest       <= r_exmem_dest;
            // Only flag the opcode once, when it actually leaves ID.
            r_illegal          <= w_dec_illegal && !w_stall && !w_take;
        end
    end

    assign forward_a = fwd_sel(r_idex_rs, r_exmem_reg_write, r_exmem_dest,
                               r_memwb_reg_write, r_memwb_dest);
    assign forward_b = fwd_sel(r_idex_rt, r_exmem_reg_write, r_exmem_dest,
                               r_memwb_reg_write, r_memwb_dest);

    assign ex_alu_op     = ALU_OP_W'(r_idex_ctrl.alu_op);
    assign ex_alu_src    = r_idex_ctrl.alu_src;
    assign ex_reg_dst    = r_idex_ctrl.reg_dst;
    assign mem_mem_read  = r_exmem_mem_read;
    assign mem_mem_write = r_exmem_mem_write;
    assign wb_reg_write  = r_memwb_reg_write;
    assign wb_mem_to_reg = r_memwb_mem_to_reg;
    assign wb_rd         = r_memwb_dest;
    assign illegal_instr = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_control_unit
// Description : Vector table plus write-back scoreboard for the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_control_unit;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADDI8 = 32'h2008_0005;
    localparam logic [31:0] ADDI9 = 32'h2009_000A;
    localparam logic [31:0] ADD   = 32'h0109_8020;
    localparam logic [31:0] SUB   = 32'h0109_8022;
    localparam logic [31:0] ANDI  = 32'h0109_8024;
    localparam logic [31:0] ORI   = 32'h0109_8025;
    localparam logic [31:0] SLT   = 32'h0109_802A;
    localparam logic [31:0] SW    = 32'hAE28_0000;
    localparam logic [31:0] LW    = 32'h8E28_0000;
    localparam logic [31:0] BEQ   = 32'h1109_0003;
    localparam logic [31:0] ILL   = 32'hFC00_0000;
    localparam int          NV    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] id_instr;
    logic        ex_zero;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_dst, mem_mem_read, mem_mem_write;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic        pc_write, ifid_write, ifid_flush, pc_src;
    logic [1:0]  forward_a, forward_b;
    logic        illegal_instr;

    pipeline_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .id_instr      (id_instr),
        .ex_zero       (ex_zero),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_dst    (ex_reg_dst),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_rd         (wb_rd),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .pc_src        (pc_src),
        .forward_a     (forward_a),
        .forward_b     (forward_b),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        pcw;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  aluop;
        logic        rdst;
        logic        asrc;
        logic        mrd;
        logic        mwr;
        logic        ill;
        logic        wwe;
        logic        wm2r;
        logic [4:0]  wrd;
    } vec_t;

    typedef struct packed {
        logic       we;
        logic       m2r;
        logic [4:0] rd;
    } wb_t;

    vec_t vecs [NV];
    wb_t  sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        input logic [31:0] i, input logic z, input logic pcw, input logic fl,
        input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] op,
        input logic rdst, input logic asrc, input logic mrd, input logic mwr,
        input logic ill, input logic we, input logic m2r, input logic [4:0] rd
    );
        vec_t v;
        v.instr = i; v.zero = z; v.pcw = pcw; v.flush = fl;
        v.fa = fa; v.fb = fb; v.aluop = op; v.rdst = rdst; v.asrc = asrc;
        v.mrd = mrd; v.mwr = mwr; v.ill = ill;
        v.wwe = we; v.wm2r = m2r; v.wrd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              instr  z  pcw fl  fa     fb     op     rd as mr mw il   we m2 rd
        vecs[0]  = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[1]  = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[2]  = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[3]  = mk(ADDI8, 0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  1, 0, 8);
        vecs[4]  = mk(ADDI9, 0, 1, 0, 2'b00, 2'b00, 4'h2, 0, 1, 0, 0, 0,  1, 0, 9);
        vecs[5]  = mk(ADD,   0, 1, 0, 2'b00, 2'b00, 4'h2, 0, 1, 0, 0, 0,  1, 0, 16);
        vecs[6]  = mk(NOP,   0, 1, 0, 2'b01, 2'b10, 4'h2, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[7]  = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[8]  = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[9]  = mk(SUB,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  1, 0, 16);
        vecs[10] = mk(ANDI,  0, 1, 0, 2'b00, 2'b00, 4'h6, 1, 0, 0, 0, 0,  1, 0, 16);
        vecs[11] = mk(ORI,   0, 1, 0, 2'b00, 2'b00, 4'h0, 1, 0, 0, 0, 0,  1, 0, 16);
        vecs[12] = mk(SLT,   0, 1, 0, 2'b00, 2'b00, 4'h1, 1, 0, 0, 0, 0,  1, 0, 16);
        vecs[13] = mk(SW,    0, 1, 0, 2'b00, 2'b00, 4'h7, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[14] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h2, 0, 1, 0, 0, 0,  0, 0, 0);
        vecs[15] = mk(ILL,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0);
        vecs[16] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 1,  0, 0, 0);
        vecs[17] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[18] = mk(LW,    0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  1, 1, 8);
        vecs[19] = mk(ADD,   0, 0, 0, 2'b00, 2'b00, 4'h2, 0, 1, 0, 0, 0,  0, 0, 0);
        vecs[20] = mk(ADD,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 1, 0, 0,  1, 0, 16);
        vecs[21] = mk(NOP,   0, 1, 0, 2'b01, 2'b00, 4'h2, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[22] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[23] = mk(BEQ,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[24] = mk(ADDI8, 1, 1, 1, 2'b00, 2'b00, 4'h6, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[25] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[26] = mk(BEQ,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[27] = mk(ADDI9, 0, 1, 0, 2'b00, 2'b00, 4'h6, 0, 0, 0, 0, 0,  1, 0, 9);
        vecs[28] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h2, 0, 1, 0, 0, 0,  0, 0, 0);
        vecs[29] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[30] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[31] = mk(NOP,   0, 1, 0, 2'b00, 2'b00, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);

        rst = 1'b1; en = 1'b1; id_instr = NOP; ex_zero = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;

        // MEM/WB starts cleared, which stands for three earlier bubble loads.
        repeat (3) sb.push_back('0);

        for (int k = 0; k < NV; k++) begin
            wb_t e;
            id_instr = vecs[k].instr;
            ex_zero  = vecs[k].zero;
            sb.push_back({vecs[k].wwe, vecs[k].wm2r, vecs[k].wrd});
            @(negedge clk);
            chk("pc_write",      k, pc_write,      vecs[k].pcw);
            chk("ifid_write",    k, ifid_write,    vecs[k].pcw);
            chk("ifid_flush",    k, ifid_flush,    vecs[k].flush);
            chk("pc_src",        k, pc_src,        vecs[k].flush);
            chk("forward_a",     k, forward_a,     vecs[k].fa);
            chk("forward_b",     k, forward_b,     vecs[k].fb);
            chk("ex_alu_op",     k, ex_alu_op,     vecs[k].aluop);
            chk("ex_reg_dst",    k, ex_reg_dst,    vecs[k].rdst);
            chk("ex_alu_src",    k, ex_alu_src,    vecs[k].asrc);
            chk("mem_mem_read",  k, mem_mem_read,  vecs[k].mrd);
            chk("mem_mem_write", k, mem_mem_write, vecs[k].mwr);
            chk("illegal_instr", k, illegal_instr, vecs[k].ill);
            e = sb.pop_front();
            chk("wb_reg_write",  k, wb_reg_write,  e.we);
            chk("wb_mem_to_reg", k, wb_mem_to_reg, e.m2r);
            chk("wb_rd",         k, wb_rd,         e.rd);
            next_cycle();
        end

        // en=0 hold with a load in EX and addi in MEM, then reset during the stall.
        id_instr = ADDI8; ex_zero = 1'b0;
        next_cycle();
        id_instr = LW;
        next_cycle();
        id_instr = ADD;
        en = 1'b0;
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            chk("hold_pc_write",   100 + h, pc_write,      0);
            chk("hold_ifid_write", 100 + h, ifid_write,    0);
            chk("hold_ifid_flush", 100 + h, ifid_flush,    0);
            chk("hold_pc_src",     100 + h, pc_src,        0);
            chk("hold_ex_alu_op",  100 + h, ex_alu_op,     4'h2);
            chk("hold_ex_alu_src", 100 + h, ex_alu_src,    1);
            chk("hold_forward_b",  100 + h, forward_b,     2'b10);
            chk("hold_forward_a",  100 + h, forward_a,     2'b00);
            chk("hold_mem_read",   100 + h, mem_mem_read,  0);
            next_cycle();
        end
        en = 1'b1;
        @(negedge clk);
        chk("stall_pc_write",   102, pc_write,   0);
        chk("stall_ifid_write", 102, ifid_write, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pc_write",     103, pc_write,      1);
        chk("rst_ifid_write",   103, ifid_write,    1);
        chk("rst_ex_alu_op",    103, ex_alu_op,     0);
        chk("rst_ex_alu_src",   103, ex_alu_src,    0);
        chk("rst_forward_b",    103, forward_b,     0);
        chk("rst_mem_read",     103, mem_mem_read,  0);
        chk("rst_wb_reg_write", 103, wb_reg_write,  0);
        chk("rst_wb_rd",        103, wb_rd,         0);
        chk("rst_illegal",      103, illegal_instr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
